// File: rtl/demux2_pkg.sv
// Shared types and constants for the registered 1-to-2 demultiplexer.
// The cnt0/cnt1 statistics ports are built only when DEMUX2_STATS_EN is defined.
package demux2_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } chan_state_e;

endpackage

// File: rtl/demux2_chan_buf.sv
// One output channel: a 2-entry FIFO whose head is always entry 0.
// next_full is exported so the top can register in_ready without any input-to-output path.
module demux2_chan_buf
  import demux2_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [n-1:0] push_data,
  input  logic         pop,
  output logic [n-1:0] head_data,
  output logic         head_valid,
  output logic         next_full
);

  chan_state_e  state_q, state_d;
  logic [n-1:0] entry_q [BUF_DEPTH];
  logic [n-1:0] entry_d [BUF_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
    end
  end

  // A pop on an empty channel is ignored; push+pop in HALF replaces the head.
  always_comb begin
    state_d    = state_q;
    entry_d[0] = entry_q[0];
    entry_d[1] = entry_q[1];
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d    = HALF;
          entry_d[0] = push_data;
        end
      end
      HALF: begin
        if (push && pop) begin
          entry_d[0] = push_data;
        end else if (push) begin
          state_d    = FULL;
          entry_d[1] = push_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d    = HALF;
          entry_d[0] = entry_q[1];
          if (push) begin
            state_d    = FULL;
            entry_d[1] = push_data;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    head_valid = (state_q != EMPTY);
    head_data  = entry_q[0];
    next_full  = (state_d == FULL);
  end

endmodule

// File: rtl/demux2_n_pipe.sv
// Registered 1-to-2 demultiplexer: steers each accepted item into one of two 2-entry channels.
// Optional feature macro: DEMUX2_STATS_EN adds the cnt0/cnt1 accepted-item counters.
module demux2_n_pipe
  import demux2_pkg::*;
#(
  parameter int n = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [n-1:0]     in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [n-1:0]     out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [n-1:0]     out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX2_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  logic in_ready_q, in_ready_d;
  logic accept, push0, push1;
  logic next_full0, next_full1;

  always_comb begin
    accept = in_valid & in_ready_q;
    push0  = accept & ~in_sel;
    push1  = accept & in_sel;
  end

  demux2_chan_buf #(.n(n)) u_chan0 (
    .clk        (clk),
    .reset      (reset),
    .push       (push0),
    .push_data  (in_data),
    .pop        (out0_ready),
    .head_data  (out0_data),
    .head_valid (out0_valid),
    .next_full  (next_full0)
  );

  demux2_chan_buf #(.n(n)) u_chan1 (
    .clk        (clk),
    .reset      (reset),
    .push       (push1),
    .push_data  (in_data),
    .pop        (out1_ready),
    .head_data  (out1_data),
    .head_valid (out1_valid),
    .next_full  (next_full1)
  );

  // Either channel going FULL stalls the input, so in_ready never depends on in_sel.
  always_comb begin
    in_ready_d = ~(next_full0 | next_full1);
    in_ready   = in_ready_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_ready_q <= 1'b0;
    else       in_ready_q <= in_ready_d;
  end

`ifdef DEMUX2_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q + CNT_W'(push0);
    cnt1_d = cnt1_q + CNT_W'(push1);
    cnt0   = cnt0_q;
    cnt1   = cnt1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
`endif

endmodule

// File: tb/tb_demux2_n_pipe.sv
// Directed and scoreboard checks for demux2_n_pipe; stats checks build only with DEMUX2_STATS_EN.
module tb_demux2_n_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0_data, out1_data;
  logic        out0_valid, out1_valid;
  logic        out0_ready, out1_ready;
`ifdef DEMUX2_STATS_EN
  logic [31:0] cnt0, cnt1;
`endif

  int checks = 0;
  int failures = 0;

  demux2_n_pipe #(.n(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DEMUX2_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || in_ready !== 1'b0 || out0_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_idle: v0=%b v1=%b rdy=%b d0=%h required 0 0 0 0", out0_valid, out1_valid, in_ready, out0_data);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release_rdy_low: got %b required 0", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_rdy: got %b required 1", in_ready);
    end
    // Fill channel 0 with 0xA, 0xB while its consumer stalls.
    out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_valid = 1'b0;
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hA || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_fill: v0=%b d0=%h rdy=%b required 1 a 0", out0_valid, out0_data, in_ready);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out0_valid !== 1'b0 || out0_data !== 32'h0 || in_ready !== 1'b0 || out1_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_async: v0=%b d0=%h rdy=%b v1=%b required 0 0 0 0", out0_valid, out0_data, in_ready, out1_valid);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    out0_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out0_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_recover: rdy=%b v0=%b required 1 0", in_ready, out0_valid);
    end
  endtask

  task automatic test_steering();
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h11;
    step();
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 32'h11 || out1_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL steer_ch0: v0=%b d0=%h v1=%b required 1 11 0", out0_valid, out0_data, out1_valid);
    end
    in_sel = 1'b1; in_data = 32'h22;
    step();
    in_valid = 1'b0;
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'h22 || out0_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL steer_ch1: v1=%b d1=%h v0=%b required 1 22 0", out1_valid, out1_data, out0_valid);
    end
    step();
    checks++;
    if (out1_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL steer_drain: v1=%b rdy=%b required 0 1", out1_valid, in_ready);
    end
  endtask

  task automatic test_back_pressure();
    out0_ready = 1'b0; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_half_rdy: got %b required 1", in_ready);
    end
    in_data = 32'h2;
    step();
    checks++;
    if (in_ready !== 1'b0 || out0_data !== 32'h1) begin
      failures++;
      $display("[TB] FAIL bp_full: rdy=%b d0=%h required 0 1", in_ready, out0_data);
    end
    in_sel = 1'b1; in_data = 32'h3;
    step();
    checks++;
    if (out1_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_held: v1=%b rdy=%b required 0 0", out1_valid, in_ready);
    end
    out0_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out0_data !== 32'h2 || out1_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_release: rdy=%b d0=%h v1=%b required 1 2 0", in_ready, out0_data, out1_valid);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'h3 || out0_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_deliver: v1=%b d1=%h v0=%b required 1 3 0", out1_valid, out1_data, out0_valid);
    end
    step();
  endtask

  task automatic test_push_pop_half();
    out0_ready = 1'b0; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h5;
    step();
    out0_ready = 1'b1; in_data = 32'h6;
    step();
    in_valid = 1'b0;
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 32'h6 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pushpop_half: v0=%b d0=%h rdy=%b required 1 6 1", out0_valid, out0_data, in_ready);
    end
    step();
    checks++;
    if (out0_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pushpop_empty: v0=%b required 0", out0_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] expv;
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    logic took;
    in_valid = 1'b0;
    while ((sent < 100 || q0.size() != 0 || q1.size() != 0) && cyc < 3000) begin
      if (!in_valid && sent < 100) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        in_sel   = 1'($urandom_range(0, 1));
      end
      out0_ready = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
      out1_ready = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out0_valid && out0_ready) begin
        checks++;
        recv++;
        if (q0.size() == 0) begin
          failures++;
          $display("[TB] FAIL rand_ch0_extra: got %h required no item", out0_data);
        end else begin
          expv = q0.pop_front();
          if (out0_data !== expv) begin
            failures++;
            $display("[TB] FAIL rand_ch0_order: got %h required %h", out0_data, expv);
          end
        end
      end
      if (out1_valid && out1_ready) begin
        checks++;
        recv++;
        if (q1.size() == 0) begin
          failures++;
          $display("[TB] FAIL rand_ch1_extra: got %h required no item", out1_data);
        end else begin
          expv = q1.pop_front();
          if (out1_data !== expv) begin
            failures++;
            $display("[TB] FAIL rand_ch1_order: got %h required %h", out1_data, expv);
          end
        end
      end
      took = in_valid && in_ready;
      if (took) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
        sent++;
      end
      step();
      if (took) in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 100 || cyc >= 3000) begin
      failures++;
      $display("[TB] FAIL rand_count: received %0d in %0d cycles, required 100 within bound", recv, cyc);
    end
  endtask

`ifdef DEMUX2_STATS_EN
  task automatic test_stats();
    logic [9:0] pat;
    pat = 10'b1010010000;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (cnt0 !== 32'd0 || cnt1 !== 32'd0) begin
      failures++;
      $display("[TB] FAIL stats_reset: cnt0=%0d cnt1=%0d required 0 0", cnt0, cnt1);
    end
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'(i); in_sel = pat[i];
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (cnt0 !== 32'd7 || cnt1 !== 32'd3) begin
      failures++;
      $display("[TB] FAIL stats_count: cnt0=%0d cnt1=%0d required 7 3", cnt0, cnt1);
    end
    force dut.cnt0_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt0_q;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h77;
    step();
    in_valid = 1'b0;
    checks++;
    if (cnt0 !== 32'd0 || cnt1 !== 32'd3) begin
      failures++;
      $display("[TB] FAIL stats_wrap: cnt0=%h cnt1=%0d required 0 3", cnt0, cnt1);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #3;
    test_reset();
    test_steering();
    test_back_pressure();
    test_push_pop_half();
    test_random();
`ifdef DEMUX2_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux2_n_pipe.md
# demux2_n_pipe

Registered 1-to-2 n-bit demultiplexer with valid/ready handshakes, the steering counterpart of the 2-to-1 select mux. One input stream is routed by a per-item select bit into one of two independent output channels, each backed by a 2-entry buffer. It sits between a producer stage and two consumer stages, for example splitting results between two pipeline paths. It provides full-rate throughput and one-cycle latency without combinational ready paths.

## Interface
- n, 32, data width in bits (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  n  item payload
- in_sel  in  1  destination: 0 = channel 0, 1 = channel 1
- in_valid  in  1  producer offers item
- in_ready  out  1  block can accept (registered)
- out0_data / out1_data  out  n  channel head payload
- out0_valid / out1_valid  out  1  channel head valid
- out0_ready / out1_ready  in  1  consumer accepts head
- cnt0 / cnt1  out  32  accepted-item counters (only with DEMUX2_STATS_EN)

## Operation
- Input transfer: in_valid && in_ready at a rising edge; the item is written to channel in_sel.
- Output transfer on channel c: outc_valid && outc_ready at a rising edge pops the head.
- Each channel is an independent 2-entry FIFO with states EMPTY, HALF, FULL:
  - EMPTY: push → HALF.
  - HALF: push only → FULL; pop only → EMPTY; push and pop together → HALF, with the new item as head.
  - FULL: pop → HALF.
  - Push while FULL cannot occur, because in_ready guards it.
- outc_valid = (state != EMPTY); outc_data = head entry.
- Order is preserved within a channel; no ordering is guaranteed across channels.
- in_ready is registered. Its next value is 1 iff neither channel's next state is FULL.
  - This is conservative: a FULL channel 1 stalls items destined for channel 0. The stall is accepted as the price of no in_sel→in_ready path.
- in_sel, in_data and in_valid are sampled only when in_ready=1. Payload changes while in_ready=0 are allowed and have no effect.
- Pop and push on different channels in the same cycle are independent.
- Reset (asynchronous, at any time, including mid-stream):
  - all channels go to EMPTY; buffered items are discarded;
  - out0_valid, out1_valid and in_ready are 0;
  - out0_data and out1_data are 0;
  - counters are 0.

## Timing
- Latency: an item accepted at edge k is visible on outc_data/outc_valid from edge k (after clock-to-q), i.e. one cycle after it is presented.
- Throughput: 1 item/cycle sustained when consumers hold ready=1. The same holds when alternating between channels.
- After reset deasserts, in_ready rises at the first rising edge.
- A channel reaching FULL drops in_ready at the same edge that causes FULL. in_ready recovers at the edge where that channel pops.
- outc_ready → in_ready is registered: no combinational paths from any input to any output.

## Configuration
- DEMUX2_STATS_EN defined:
  - cnt0 and cnt1 exist.
  - Each increments by 1 on every input transfer to its channel.
  - Each wraps from 0xFFFFFFFF to 0.
  - Each resets to 0.
- Undefined: the cnt ports and counter logic are absent. All other behaviour is identical.

## Structure
- Package demux2_pkg:
  - channel state type (EMPTY, HALF, FULL);
  - localparam BUF_DEPTH = 2;
  - counter width constant CNT_W = 32.
- Sub-module demux2_chan_buf holds one channel's 2-entry buffer and state machine. It has ports push, push_data, pop, head_data, head_valid, and next_full.
- It is instantiated twice. The top level contains only push steering, in_ready registration and the optional counters.

## Test plan
- Reset mid-stream: with channel 0 FULL holding 0xA, 0xB, assert reset → out0_valid=0, out0_data=0, in_ready=0. After release, in_ready=1 one edge later.
- Steering: push 0x11 (sel=0) then 0x22 (sel=1), both consumers ready → out0 shows 0x11 and out1 shows 0x22, each one cycle after its push.
- Back-pressure: out0_ready=0; push 0x1, 0x2 to channel 0 → in_ready=0 after the second push. Push 0x3 (sel=1) is held and not accepted. Raise out0_ready → 0x1 pops, then in_ready=1 and 0x3 reaches channel 1.
- Simultaneous push/pop in HALF: channel 0 holds 0x5, out0_ready=1, push 0x6 → next cycle head=0x6, state HALF, in_ready stays 1.
- Sustained rate: 100 random items, random sel, random consumer ready → per-channel order matches a scoreboard, with no loss or duplication.
- With DEMUX2_STATS_EN: 7 pushes to channel 0 and 3 to channel 1 → cnt0=7, cnt1=3. Preload a counter to 0xFFFFFFFF and push once → it reads 0.
